// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: word-addressed RAM behind a processor Memory stage.
// The request is stalled through DataWaitreq for a fixed number of wait states per op type.
module data_mem_ctrl #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDR_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 ReadData,
  input  logic                 WriteData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic                 ErrorFlag,
  output logic [15:0]          WaitCycles
);
  typedef enum logic {S_IDLE, S_WAIT} state_e;

  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
  localparam logic [3:0] WR_LAT = 4'(WRITE_LATENCY);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 wr_q, wr_d;
  logic                 err_q, err_d;
  logic [15:0]          wait_q, wait_d;
  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];

  logic                 req, waitreq, done, done_wr;
  logic [3:0]           lat;
  logic [ADDR_BITS-1:0] done_addr;
  logic [WORD_SIZE-1:0] done_data;

  // Upper address bits alias onto the RAM and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^DataAddr[WORD_SIZE-1:ADDR_BITS];

  always_comb begin
    req       = ReadData | WriteData;
    lat       = WriteData ? WR_LAT : RD_LAT;
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    waitreq   = 1'b0;
    done      = 1'b0;
    done_wr   = WriteData;
    done_addr = DataAddr[ADDR_BITS-1:0];
    done_data = DataOut;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (lat == 4'd0) begin
            done = 1'b1;
          end else begin
            waitreq = 1'b1;
            addr_d  = DataAddr[ADDR_BITS-1:0];
            data_d  = DataOut;
            wr_d    = WriteData;
            cnt_d   = lat - 4'd1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Only the latched request matters here; live inputs only signal abort.
        done_wr   = wr_q;
        done_addr = addr_q;
        done_data = data_q;
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          waitreq = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (Reset) begin
      waitreq = 1'b0;
      done    = 1'b0;
    end
    err_d  = err_q | (ReadData & WriteData);
    wait_d = (waitreq && wait_q != 16'hFFFF) ? wait_q + 16'd1 : wait_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (done && done_wr) mem[done_addr] <= done_data;
  end

  assign DataIn      = (done && !done_wr) ? mem[done_addr] : '0;
  assign DataWaitreq = waitreq;
  assign ErrorFlag   = err_q;
  assign WaitCycles  = wait_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboarded bench for data_mem_ctrl: default-latency instance plus a zero-latency instance.
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] DataAddr, DataOut, DataIn, WaitCycles;
  logic        ReadData, WriteData, DataWaitreq, ErrorFlag;
  logic [15:0] b_addr, b_dout, b_din, b_wait;
  logic        b_rd, b_wr, b_waitreq, b_err;

  int checks = 0;
  int errors = 0;
  logic [15:0] model [256];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .Clock(clk), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
    .ReadData(ReadData), .WriteData(WriteData), .DataIn(DataIn),
    .DataWaitreq(DataWaitreq), .ErrorFlag(ErrorFlag), .WaitCycles(WaitCycles)
  );

  data_mem_ctrl #(.READ_LATENCY(0), .WRITE_LATENCY(0)) dut_z (
    .Clock(clk), .Reset(Reset), .DataAddr(b_addr), .DataOut(b_dout),
    .ReadData(b_rd), .WriteData(b_wr), .DataIn(b_din),
    .DataWaitreq(b_waitreq), .ErrorFlag(b_err), .WaitCycles(b_wait)
  );

  // One request on the default instance; alt_addr replaces DataAddr once the wait begins.
  task automatic op_a(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [15:0] data, input int lat, input logic [15:0] alt_addr,
                      input string name);
    int hi = 0;
    bit done = 0;
    logic [15:0] exp;
    ReadData = rd; WriteData = wr; DataAddr = addr; DataOut = data;
    if (rd && !wr) exp_q.push_back(model[addr[7:0]]);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (DataWaitreq) begin
        hi++;
        checks++;
        if (DataIn !== 16'h0) begin
          errors++; $display("FAIL %s wait-cycle DataIn got %h want 0000", name, DataIn);
        end
      end else begin
        done = 1;
        checks++;
        if (hi != lat) begin
          errors++; $display("FAIL %s wait cycles got %0d want %0d", name, hi, lat);
        end
        exp = 16'h0;
        if (rd && !wr) exp = exp_q.pop_front();
        checks++;
        if (DataIn !== exp) begin
          errors++; $display("FAIL %s DataIn got %h want %h", name, DataIn, exp);
        end
        if (wr) model[addr[7:0]] = data;
      end
      @(posedge clk); #1;
      if (!done) DataAddr = alt_addr;
    end
    if (!done) begin
      errors++; $display("FAIL %s timeout waiting for completion", name);
    end
  endtask

  task automatic idle_inputs();
    ReadData = 0; WriteData = 0; DataAddr = 16'h0; DataOut = 16'h0;
    b_rd = 0; b_wr = 0; b_addr = 16'h0; b_dout = 16'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1;
    @(posedge clk); #1;
    ReadData = 1; b_rd = 1;
    @(negedge clk);
    checks++;
    if (DataWaitreq !== 1'b0 || DataIn !== 16'h0) begin
      errors++; $display("FAIL reset_outputs waitreq=%b DataIn=%h want 0/0000", DataWaitreq, DataIn);
    end
    @(posedge clk); #1;
    idle_inputs();
    Reset = 0;
    @(negedge clk);
    checks++;
    if (WaitCycles !== 16'h0 || ErrorFlag !== 1'b0 || b_wait !== 16'h0) begin
      errors++; $display("FAIL reset_state WaitCycles=%h ErrorFlag=%b want 0000/0", WaitCycles, ErrorFlag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    op_a(0, 1, 16'h0005, 16'hBEEF, 1, 16'h0005, "wr5");
    op_a(1, 0, 16'h0005, 16'h0000, 2, 16'h0005, "rd5");
    idle_inputs();
    @(negedge clk);
    checks++;
    if (WaitCycles !== 16'd3) begin
      errors++; $display("FAIL waitcycles_wr_rd got %0d want 3", WaitCycles);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alias();
    op_a(0, 1, 16'h0105, 16'h1234, 1, 16'h0105, "wr105");
    op_a(1, 0, 16'h0005, 16'h0000, 2, 16'h0005, "rd_alias");
  endtask

  task automatic test_zero_latency();
    b_wr = 1; b_addr = 16'h000A; b_dout = 16'h0042;
    @(negedge clk);
    checks++;
    if (b_waitreq !== 1'b0 || b_din !== 16'h0) begin
      errors++; $display("FAIL zl_write waitreq=%b DataIn=%h want 0/0000", b_waitreq, b_din);
    end
    @(posedge clk); #1;
    b_wr = 0; b_rd = 1; b_dout = 16'h0;
    exp_q.push_back(16'h0042);
    @(negedge clk);
    checks++;
    if (b_waitreq !== 1'b0 || b_din !== exp_q[0]) begin
      errors++; $display("FAIL zl_read waitreq=%b DataIn=%h want 0/%h", b_waitreq, b_din, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    b_rd = 0;
    @(negedge clk);
    checks++;
    if (b_wait !== 16'h0 || b_din !== 16'h0) begin
      errors++; $display("FAIL zl_after WaitCycles=%h DataIn=%h want 0000/0000", b_wait, b_din);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    op_a(0, 1, 16'h0003, 16'h0000, 1, 16'h0003, "wr3_zero");
    WriteData = 1; DataAddr = 16'h0003; DataOut = 16'hAAAA;
    @(negedge clk);
    checks++;
    if (DataWaitreq !== 1'b1) begin
      errors++; $display("FAIL abort_start waitreq got %b want 1", DataWaitreq);
    end
    @(posedge clk); #1;
    WriteData = 0;
    @(negedge clk);
    checks++;
    if (DataWaitreq !== 1'b0 || DataIn !== 16'h0) begin
      errors++; $display("FAIL abort_cycle waitreq=%b DataIn=%h want 0/0000", DataWaitreq, DataIn);
    end
    @(posedge clk); #1;
    op_a(1, 0, 16'h0003, 16'h0000, 2, 16'h0003, "rd3_after_abort");
  endtask

  task automatic test_illegal_and_latch();
    op_a(1, 1, 16'h0007, 16'h5555, 1, 16'h0007, "both_high");
    checks++;
    if (ErrorFlag !== 1'b1) begin
      errors++; $display("FAIL error_flag got %b want 1", ErrorFlag);
    end
    op_a(1, 0, 16'h0007, 16'h0000, 2, 16'h0007, "rd7");
    op_a(1, 0, 16'h0005, 16'h0000, 2, 16'h0007, "rd_latched_addr");
    checks++;
    if (ErrorFlag !== 1'b1) begin
      errors++; $display("FAIL error_sticky got %b want 1", ErrorFlag);
    end
  endtask

  task automatic test_reset_mid_op();
    op_a(0, 1, 16'h0009, 16'h1111, 1, 16'h0009, "wr9_init");
    WriteData = 1; ReadData = 0; DataAddr = 16'h0009; DataOut = 16'h7777;
    @(negedge clk);
    checks++;
    if (DataWaitreq !== 1'b1) begin
      errors++; $display("FAIL rst_mid_start waitreq got %b want 1", DataWaitreq);
    end
    @(posedge clk); #1;
    Reset = 1;
    @(negedge clk);
    checks++;
    if (DataWaitreq !== 1'b0 || DataIn !== 16'h0) begin
      errors++; $display("FAIL rst_mid_cycle waitreq=%b DataIn=%h want 0/0000", DataWaitreq, DataIn);
    end
    @(posedge clk); #1;
    Reset = 0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (WaitCycles !== 16'h0 || ErrorFlag !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state WaitCycles=%h ErrorFlag=%b want 0000/0", WaitCycles, ErrorFlag);
    end
    @(posedge clk); #1;
    op_a(1, 0, 16'h0009, 16'h0000, 2, 16'h0009, "rd9_after_reset");
  endtask

  initial begin
    idle_inputs();
    Reset = 1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_alias();
    test_zero_latency();
    test_abort();
    test_illegal_and_latch();
    test_reset_mid_op();
    idle_inputs();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain %0d entries left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
